// File: rtl/tx_polyphase_fir.sv
`default_nettype none
// ============================================================================
//  Module   : tx_polyphase_fir
//  Purpose  : 4-phase polyphase interpolating FIR for the Tx path. Accepts one
//             BPSK symbol per symbol period (on the clock where i_phase == 0)
//             and produces one full-precision shaped sample per clock, giving
//             4x oversampling over a 16-tap prototype (4 taps per phase).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1           clock
//    i_rst     in   1           asynchronous active-high reset
//    i_phase   in   NB_COUNTER  phase from the Tx FIR control counter
//    i_symbol  in   1           BPSK bit (0 -> +1, 1 -> -1)
//    i_valid   in   1           symbol present, sampled when i_phase == 0
//    o_data    out  NB_OUTPUT   filtered sample, signed two's complement
//    o_phase   out  NB_COUNTER  phase that o_data was computed for
//    o_valid   out  1           o_data meaningful (1 from first edge after reset)
// ----------------------------------------------------------------------------
//  Parameters
//    NB_COUNTER  phase width; number of phases is 2**NB_COUNTER
//    N_TAPS_PH   taps per phase (symbol shift register depth)
//    NB_COEFF    coefficient width, signed S(NB_COEFF, NB_COEFF-1)
//    NB_OUTPUT   output width; must equal NB_COEFF+3 (full precision)
//    COEFFS      packed coefficient set, c[i] at [NB_COEFF*i +: NB_COEFF]
// ============================================================================
module tx_polyphase_fir #(
  parameter int NB_COUNTER = 2,
  parameter int N_TAPS_PH  = 4,
  parameter int NB_COEFF   = 8,
  parameter int NB_OUTPUT  = 11,
  parameter logic [NB_COEFF*N_TAPS_PH*(2**NB_COUNTER)-1:0] COEFFS =
    128'hFD_FA_FB_00_0D_20_33_40_33_20_0D_00_FB_FA_FD_00
) (
  input  logic                        clk,
  input  logic                        i_rst,
  input  logic [NB_COUNTER-1:0]       i_phase,
  input  logic                        i_symbol,
  input  logic                        i_valid,
  output logic signed [NB_OUTPUT-1:0] o_data,
  output logic [NB_COUNTER-1:0]       o_phase,
  output logic                        o_valid
);

  localparam int c_NPH = 2**NB_COUNTER;
  localparam int c_EXT = NB_OUTPUT - NB_COEFF;

  // --------------------------------------------------------------------------
  // Symbol shift register: one {occ, sym} pair per tap, index 0 is newest.
  // --------------------------------------------------------------------------
  logic [N_TAPS_PH-1:0] r_occ;
  logic [N_TAPS_PH-1:0] r_sym;
  logic [N_TAPS_PH-1:0] w_occ_nxt;
  logic [N_TAPS_PH-1:0] w_sym_nxt;
  logic                 w_shift;

  // Phase sequencing is not policed: every phase-0 edge shifts, others hold.
  assign w_shift = (i_phase == '0);

  always_comb begin
    w_occ_nxt = r_occ;
    w_sym_nxt = r_sym;
    if (w_shift) begin
      for (int k = N_TAPS_PH - 1; k > 0; k--) begin
        w_occ_nxt[k] = r_occ[k-1];
        w_sym_nxt[k] = r_sym[k-1];
      end
      // An absent symbol shifts in an empty slot (zero stuffing / flush).
      w_occ_nxt[0] = i_valid;
      w_sym_nxt[0] = i_symbol;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_occ <= '0;
      r_sym <= '0;
    end else begin
      r_occ <= w_occ_nxt;
      r_sym <= w_sym_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Tap contributions. The MAC works on the post-update register content so a
  // symbol accepted at phase 0 already appears in the same-edge output.
  // Negation is done after sign extension so the most negative coefficient
  // negates exactly.
  // --------------------------------------------------------------------------
  logic signed [NB_OUTPUT-1:0] w_contrib [N_TAPS_PH];

  for (genvar k = 0; k < N_TAPS_PH; k++) begin : g_tap
    logic signed [NB_COEFF-1:0]  w_coef_ph [c_NPH];
    logic signed [NB_COEFF-1:0]  w_coef_sel;
    logic signed [NB_OUTPUT-1:0] w_coef_ext;
    logic signed [NB_OUTPUT-1:0] w_tap;

    // Tap k of phase p uses prototype coefficient c[k*NPH + p].
    for (genvar p = 0; p < c_NPH; p++) begin : g_phase
      assign w_coef_ph[p] = COEFFS[(k*c_NPH + p)*NB_COEFF +: NB_COEFF];
    end

    assign w_coef_sel = w_coef_ph[i_phase];
    assign w_coef_ext = {{c_EXT{w_coef_sel[NB_COEFF-1]}}, w_coef_sel};

    always_comb begin
      w_tap = '0;
      if (w_occ_nxt[k]) begin
        w_tap = w_sym_nxt[k] ? -w_coef_ext : w_coef_ext;
      end
    end

    assign w_contrib[k] = w_tap;
  end

  // Adder tree; the full range of N_TAPS_PH * |c|max fits NB_OUTPUT bits.
  logic signed [NB_OUTPUT-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N_TAPS_PH; k++) begin
      w_sum = w_sum + w_contrib[k];
    end
  end

  // --------------------------------------------------------------------------
  // Output registers.
  // --------------------------------------------------------------------------
  logic signed [NB_OUTPUT-1:0] r_data;
  logic [NB_COUNTER-1:0]       r_phase;
  logic                        r_valid;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_phase <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_sum;
      r_phase <= i_phase;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_phase = r_phase;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_tx_polyphase_fir.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_polyphase_fir
//  Purpose  : Self-checking bench for tx_polyphase_fir. Two instances share
//             stimulus: one with the default prototype and one with every
//             coefficient at -128 (full-scale). Expected outputs come from a
//             symbol-history convolution model with integer arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_polyphase_fir;

  logic               clk = 1'b0;
  logic               i_rst = 1'b0;
  logic [1:0]         i_phase = 2'd0;
  logic               i_symbol = 1'b0;
  logic               i_valid = 1'b0;
  logic signed [10:0] o_data;
  logic [1:0]         o_phase;
  logic               o_valid;
  logic signed [10:0] fs_data;
  logic [1:0]         fs_phase;
  logic               fs_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_polyphase_fir dut (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_phase  (i_phase),
    .i_symbol (i_symbol),
    .i_valid  (i_valid),
    .o_data   (o_data),
    .o_phase  (o_phase),
    .o_valid  (o_valid)
  );

  tx_polyphase_fir #(.COEFFS({16{8'h80}})) dut_fs (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_phase  (i_phase),
    .i_symbol (i_symbol),
    .i_valid  (i_valid),
    .o_data   (fs_data),
    .o_phase  (fs_phase),
    .o_valid  (fs_valid)
  );

  // Reference model: prototype taps and the history of accepted symbol slots
  // (+1, -1, or 0 for an empty slot), newest first.
  int c_def [16] = '{0, -3, -6, -5, 0, 13, 32, 51, 64, 51, 32, 13, 0, -5, -6, -3};
  int hist [$];
  int exp_valid = 0;
  int exp_phase = 0;

  function automatic int model_out(input int ph, input bit full_scale);
    int acc = 0;
    for (int k = 0; k < hist.size() && k < 4; k++) begin
      acc += hist[k] * (full_scale ? -128 : c_def[4*k + ph]);
    end
    return acc;
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},    int'(o_data),  model_out(exp_phase, 1'b0));
    check({tag, ".phase"},   int'(o_phase), exp_phase);
    check({tag, ".valid"},   int'(o_valid), exp_valid);
    check({tag, ".fs_data"}, int'(fs_data), model_out(exp_phase, 1'b1));
    check({tag, ".fs_valid"}, int'(fs_valid), exp_valid);
  endtask

  // One clock: drive inputs, clock, update the model, compare both instances.
  task automatic step(input string tag, input int ph, input bit v, input bit s);
    i_phase  = ph[1:0];
    i_valid  = v;
    i_symbol = s;
    @(posedge clk);
    #1;
    if (ph == 0) begin
      hist.push_front(v ? (s ? -1 : 1) : 0);
      if (hist.size() > 4) void'(hist.pop_back());
    end
    exp_phase = ph;
    exp_valid = 1;
    check_all(tag);
  endtask

  // One symbol period of normal phase sequencing.
  task automatic symbol(input string tag, input bit v, input bit s);
    for (int p = 0; p < 4; p++) step(tag, p, v, s);
  endtask

  task automatic apply_reset(input string tag);
    #2;
    i_rst = 1'b1;
    #1;
    hist.delete();
    exp_valid = 0;
    exp_phase = 0;
    check({tag, ".data"},  int'(o_data),  0);
    check({tag, ".phase"}, int'(o_phase), 0);
    check({tag, ".valid"}, int'(o_valid), 0);
    check({tag, ".fs_data"}, int'(fs_data), 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  int impulse [16] = '{0, -3, -6, -5, 0, 13, 32, 51, 64, 51, 32, 13, 0, -5, -6, -3};
  int steady [4] = '{64, 56, 52, 56};
  int held;

  initial begin
    // Reset from power-up.
    #1;
    apply_reset("por");
    for (int i = 0; i < 2; i++) symbol("idle", 1'b0, 1'b0);

    // Positive impulse, checked against the literal prototype too.
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 4; p++) begin
        step("imp", p, (i == 0 && p == 0), 1'b0);
        check("imp.lit", int'(o_data), impulse[4*i + p]);
      end
    end
    for (int i = 0; i < 2; i++) symbol("imp_tail", 1'b0, 1'b0);
    check("imp.zero", int'(o_data), 0);

    // Negative impulse.
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 4; p++) begin
        step("nimp", p, (i == 0 && p == 0), 1'b1);
        check("nimp.lit", int'(o_data), -impulse[4*i + p]);
      end
    end

    // Steady symbol 1: -64,-56,-52,-56 and full-scale +512.
    for (int i = 0; i < 6; i++) symbol("ss1", 1'b1, 1'b1);
    for (int p = 0; p < 4; p++) begin
      step("ss1", p, 1'b1, 1'b1);
      check("ss1.lit", int'(o_data), -steady[p]);
      check("fs.512", int'(fs_data), 512);
    end

    // Steady symbol 0: 64,56,52,56 and full-scale -512.
    for (int i = 0; i < 5; i++) symbol("ss0", 1'b1, 1'b0);
    for (int p = 0; p < 4; p++) begin
      step("ss0", p, 1'b1, 1'b0);
      check("ss0.lit", int'(o_data), steady[p]);
      check("fs.m512", int'(fs_data), -512);
    end

    // Asynchronous reset mid-run while o_data is nonzero.
    step("pre_rst", 1, 1'b1, 1'b0);
    check("pre_rst.nz", int'(o_data != 0), 1);
    apply_reset("midrst");
    for (int i = 0; i < 2; i++) symbol("post_rst", 1'b0, 1'b0);

    // Phase anomalies: three consecutive phase-0 edges shift three symbols.
    step("rep0", 0, 1'b1, 1'b0);
    step("rep0", 0, 1'b1, 1'b1);
    step("rep0", 0, 1'b1, 1'b0);
    // x = +1,-1,+1 at phase 0: c0 - c4 + c8 = 64.
    check("rep0.lit", int'(o_data), 64);
    step("hold2", 2, 1'b1, 1'b1);
    held = int'(o_data);
    for (int i = 0; i < 5; i++) begin
      step("hold2", 2, $urandom_range(0, 1), $urandom_range(0, 1));
      check("hold2.const", int'(o_data), held);
    end

    // Randomised: normal sequencing with random valid/symbol.
    for (int i = 0; i < 40; i++) begin
      symbol("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 1));
    end
    // Randomised: arbitrary phase sequences.
    for (int i = 0; i < 120; i++) begin
      step("rndph", $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
